mux_share_arbiter: RTL and testbench

- Two-requester arbiter and output stage for the shared 32-bit 2-to-1 word selector in the datapath.
- Decides which of two valid/ready sources drives the shared 32-bit word each cycle, and drives the selector's Sel.
- Captures the selected word into a one-entry output register with a valid/ready handshake toward the consumer (register-file write port / bus).
- Policy: round-robin with a bounded burst length, so one source cannot starve the other.

---
 rtl/mux_share_arbiter.sv | 117 +++++++++++
 tb/tb_mux_share_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// Two-source round-robin arbiter with bounded bursts, driving the shared word selector
// and a one-entry valid/ready output register.
module mux_share_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [2*WIDTH-1:0] In,
    input  logic [1:0]         Req_Valid,
    output logic [1:0]         Req_Ready,
    output logic               Sel,
    output logic [WIDTH-1:0]   Out,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [1:0]         Owner
);

    // Encoding doubles as the Owner output value.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               le;
    logic               owner_valid;
    logic               owner_idx;
    logic               grant;
    logic               grant_valid;

    assign le          = ~out_valid_q | Out_Ready;
    assign owner_valid = (state_q != StIdle);
    assign owner_idx   = (state_q == StOwn1);

    // Grant decision; only depends on registered state, Req_Valid and Out_Ready.
    always_comb begin
        grant       = last_q;
        grant_valid = le & (|Req_Valid);
        if (!owner_valid) begin
            if (&Req_Valid) begin
                grant = ~last_q;
            end else begin
                grant = Req_Valid[1];
            end
        end else if (Req_Valid[owner_idx] &&
                     (!Req_Valid[~owner_idx] || (cnt_q < MaxBurst))) begin
            grant = owner_idx;
        end else begin
            grant = ~owner_idx;
        end
    end

    always_comb begin
        Req_Ready = 2'b00;
        if (Rst_n && grant_valid) begin
            Req_Ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign Sel = grant_valid ? grant : last_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (le) begin
            if (grant_valid) begin
                out_d       = grant ? In[2*WIDTH-1:WIDTH] : In[WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = grant ? StOwn1 : StOwn0;
                last_d      = grant;
                // Count restarts whenever ownership moves, so MAX_BURST=1 alternates.
                if (owner_valid && (owner_idx == grant)) begin
                    cnt_d = (cnt_q >= MaxBurst) ? MaxBurst : cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd1;
                end
            end else begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
                cnt_d       = 4'd0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cnt_q       <= 4'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Out       = out_q;
    assign Out_Valid = out_valid_q;
    assign Owner     = state_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the round-robin/burst policy.
module tb_mux_share_arbiter;

    localparam int W  = 32;
    localparam int MB = 4;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [2*W-1:0] In;
    logic [1:0]    Req_Valid;
    logic [1:0]    Req_Ready;
    logic          Sel;
    logic [W-1:0]  Out;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [1:0]    Owner;

    int checks   = 0;
    int failures = 0;

    mux_share_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In        (In),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Sel       (Sel),
        .Out       (Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Owner     (Owner)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Req_Valid = 2'b00; Out_Ready = 1'b1; In = '0;
        cyc(); cyc();
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        Rst_n = 1'b0; Req_Valid = 2'b11; #1;
        checks++; if (Req_Ready !== 2'b00) begin failures++; $display("FAIL rst_ready_held: got %b want 00", Req_Ready); end
        Req_Valid = 2'b00; Rst_n = 1'b1; #1;
        checks++; if (Out !== '0) begin failures++; $display("FAIL rst_out: got %h want 0", Out); end
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", Out_Valid); end
        checks++; if (Owner !== 2'b00) begin failures++; $display("FAIL rst_owner: got %b want 00", Owner); end
        checks++; if (Req_Ready !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", Req_Ready); end
        checks++; if (Sel !== 1'b1) begin failures++; $display("FAIL rst_sel: got %b want 1", Sel); end
        cyc();
    endtask

    task automatic test_single_stream();
        Out_Ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            Req_Valid = 2'b01; In = {32'h0, 32'h10 + 32'(k)}; #1;
            checks++; if (Req_Ready !== 2'b01) begin failures++; $display("FAIL stream_ready[%0d]: got %b want 01", k, Req_Ready); end
            checks++; if (Sel !== 1'b0) begin failures++; $display("FAIL stream_sel[%0d]: got %b want 0", k, Sel); end
            cyc();
            checks++; if (Out !== 32'h10 + 32'(k) || Out_Valid !== 1'b1) begin failures++; $display("FAIL stream_out[%0d]: got %h/%b want %h/1", k, Out, Out_Valid, 32'h10 + 32'(k)); end
            checks++; if (Owner !== 2'b01) begin failures++; $display("FAIL stream_owner[%0d]: got %b want 01", k, Owner); end
        end
        Req_Valid = 2'b00; cyc();
    endtask

    task automatic test_contention();
        int a = 0;
        int b = 0;
        int src;
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            src = (i / MB) % 2;
            Req_Valid = 2'b11; In = {32'hB0 + 32'(b), 32'hA0 + 32'(a)}; #1;
            checks++; if (Req_Ready !== (src == 1 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL contention_ready[%0d]: got %b want src %0d", i, Req_Ready, src); end
            want = (src == 1) ? 32'hB0 + 32'(b) : 32'hA0 + 32'(a);
            if (src == 1) b++; else a++;
            cyc();
            checks++; if (Out !== want) begin failures++; $display("FAIL contention_out[%0d]: got %h want %h", i, Out, want); end
        end
        Req_Valid = 2'b00; cyc();
    endtask

    task automatic test_tie_from_idle();
        do_reset();
        Req_Valid = 2'b11; In = {32'h5555, 32'h4444}; #1;
        checks++; if (Req_Ready !== 2'b01) begin failures++; $display("FAIL tie_first: got %b want 01", Req_Ready); end
        cyc();
        Req_Valid = 2'b00; cyc();
        Req_Valid = 2'b11; #1;
        checks++; if (Req_Ready !== 2'b10 || Sel !== 1'b1) begin failures++; $display("FAIL tie_second: got %b/%b want 10/1", Req_Ready, Sel); end
        cyc();
        checks++; if (Owner !== 2'b10 || Out !== 32'h5555) begin failures++; $display("FAIL tie_owner: got %b/%h want 10/00005555", Owner, Out); end
        Req_Valid = 2'b00; cyc();
    endtask

    task automatic test_backpressure();
        Out_Ready = 1'b1;
        Req_Valid = 2'b01;
        In = {32'h0, 32'h1}; cyc();
        In = {32'h0, 32'h2}; cyc();
        In = {32'h0, 32'h12345678}; cyc();
        Out_Ready = 1'b0; Req_Valid = 2'b11; In = {32'h22222222, 32'h11111111};
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (Req_Ready !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d]: got %b want 00", k, Req_Ready); end
            checks++; if (Out !== 32'h12345678 || Out_Valid !== 1'b1 || Owner !== 2'b01) begin failures++; $display("FAIL bp_hold[%0d]: got %h/%b/%b want 12345678/1/01", k, Out, Out_Valid, Owner); end
            cyc();
        end
        Out_Ready = 1'b1; #1;
        checks++; if (Req_Ready !== 2'b01) begin failures++; $display("FAIL bp_release_ready: got %b want 01", Req_Ready); end
        cyc();
        checks++; if (Out !== 32'h11111111 || Out_Valid !== 1'b1) begin failures++; $display("FAIL bp_reload: got %h/%b want 11111111/1", Out, Out_Valid); end
        In = {32'h22222222, 32'h33333333}; #1;
        checks++; if (Req_Ready !== 2'b10) begin failures++; $display("FAIL bp_burst_switch: got %b want 10", Req_Ready); end
        cyc();
        checks++; if (Out !== 32'h22222222 || Owner !== 2'b10) begin failures++; $display("FAIL bp_switch_out: got %h/%b want 22222222/10", Out, Owner); end
        Req_Valid = 2'b00; cyc();
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        Req_Valid = 2'b10; In = {32'hC0, 32'h0}; cyc();
        In = {32'hC1, 32'h0}; cyc();
        checks++; if (Owner !== 2'b10 || Out_Valid !== 1'b1 || Out !== 32'hC1) begin failures++; $display("FAIL mid_pre: got %b/%b/%h want 10/1/c1", Owner, Out_Valid, Out); end
        Rst_n = 1'b0; Req_Valid = 2'b00; cyc();
        Rst_n = 1'b1; #1;
        checks++; if (Out !== '0 || Out_Valid !== 1'b0 || Owner !== 2'b00) begin failures++; $display("FAIL mid_reset: got %h/%b/%b want 0/0/00", Out, Out_Valid, Owner); end
        Req_Valid = 2'b11; #1;
        checks++; if (Req_Ready !== 2'b01) begin failures++; $display("FAIL mid_tie: got %b want 01", Req_Ready); end
        cyc();
        Req_Valid = 2'b00; cyc();
    endtask

    task automatic test_random();
        int m_owner, m_last, m_run, m_valid, g;
        logic [31:0] m_out;
        bit hv[2];
        logic [31:0] w[2];
        bit ordy, rst, le;
        logic [1:0] exp_ready, exp_owner;
        do_reset();
        m_owner = -1; m_last = 1; m_run = 0; m_valid = 0; m_out = '0;
        hv[0] = 0; hv[1] = 0; w[0] = '0; w[1] = '0;
        for (int n = 0; n < 2000; n++) begin
            ordy = ($urandom_range(3) != 0);
            rst  = ($urandom_range(149) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!hv[i]) begin
                    hv[i] = 1'($urandom_range(1));
                    w[i]  = $urandom;
                end
            end
            Rst_n = ~rst; Req_Valid = {hv[1], hv[0]}; In = {w[1], w[0]}; Out_Ready = ordy;
            #1;
            le = (m_valid == 0) || ordy;
            g = -1;
            if (le && (hv[0] || hv[1])) begin
                if (m_owner < 0) g = (hv[0] && hv[1]) ? 1 - m_last : (hv[0] ? 0 : 1);
                else if (hv[m_owner] && (!hv[1 - m_owner] || m_run < MB)) g = m_owner;
                else g = 1 - m_owner;
            end
            exp_ready = (rst || g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
            exp_owner = (m_owner < 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
            checks++; if (Req_Ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, Req_Ready, exp_ready); end
            if (!rst) begin
                checks++; if (Sel !== 1'((g >= 0) ? g : m_last)) begin failures++; $display("FAIL rnd_sel[%0d]: got %b want %0d", n, Sel, (g >= 0) ? g : m_last); end
            end
            checks++; if (Out !== m_out || Out_Valid !== 1'(m_valid)) begin failures++; $display("FAIL rnd_out[%0d]: got %h/%b want %h/%0d", n, Out, Out_Valid, m_out, m_valid); end
            checks++; if (Owner !== exp_owner) begin failures++; $display("FAIL rnd_owner[%0d]: got %b want %b", n, Owner, exp_owner); end
            @(posedge Clk);
            if (rst) begin
                m_owner = -1; m_last = 1; m_run = 0; m_valid = 0; m_out = '0;
            end else if (le) begin
                if (g >= 0) begin
                    m_out = w[g]; m_valid = 1;
                    m_run = (m_owner == g) ? m_run + 1 : 1;
                    m_owner = g; m_last = g; hv[g] = 0;
                end else begin
                    m_valid = 0; m_owner = -1; m_run = 0;
                end
            end
            @(negedge Clk);
        end
        Rst_n = 1'b1; Req_Valid = 2'b00; Out_Ready = 1'b1; cyc();
    endtask

    initial begin
        Rst_n = 1'b0; Req_Valid = 2'b00; Out_Ready = 1'b1; In = '0;
        @(negedge Clk);
        test_reset();
        test_single_stream();
        test_contention();
        test_tie_from_idle();
        test_backpressure();
        test_mid_burst_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
